// File: rtl/ue14500_wide.sv
//==============================================================================
// ue14500_wide : WIDTH-bit single-edge UE14500 control unit, registered strobes.
// Optional feature macro: UE_IO_GATE_EN (IEN/OEN gating of operand and stores).
// Revision: 1.0
//==============================================================================
`default_nettype none

module ue14500_wide #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       IR,
  input  logic [WIDTH-1:0] DATAIN,
  output logic             FL0,
  output logic             JMP,
  output logic             RTN,
  output logic             FLF,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             WRT,
  output logic [WIDTH-1:0] RR,
  output logic             C
);

  localparam logic [3:0] c_op_nop0 = 4'h0;
  localparam logic [3:0] c_op_ld   = 4'h1;
  localparam logic [3:0] c_op_add  = 4'h2;
  localparam logic [3:0] c_op_sub  = 4'h3;
  localparam logic [3:0] c_op_one  = 4'h4;
  localparam logic [3:0] c_op_nand = 4'h5;
  localparam logic [3:0] c_op_or   = 4'h6;
  localparam logic [3:0] c_op_xor  = 4'h7;
  localparam logic [3:0] c_op_sto  = 4'h8;
  localparam logic [3:0] c_op_stoc = 4'h9;
  localparam logic [3:0] c_op_ien  = 4'hA;
  localparam logic [3:0] c_op_oen  = 4'hB;
  localparam logic [3:0] c_op_jmp  = 4'hC;
  localparam logic [3:0] c_op_rtn  = 4'hD;
  localparam logic [3:0] c_op_skz  = 4'hE;
  localparam logic [3:0] c_op_nopf = 4'hF;

  logic             r_skip;
  logic             w_ien;
  logic             w_oen;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;

  logic [WIDTH-1:0] w_rr_nx;
  logic             w_c_nx;
  logic             w_ien_nx;
  logic             w_oen_nx;
  logic             w_skip_nx;
  logic             w_fl0_nx;
  logic             w_jmp_nx;
  logic             w_rtn_nx;
  logic             w_flf_nx;
  logic             w_wrt_nx;
  logic [WIDTH-1:0] w_dout_nx;

`ifdef UE_IO_GATE_EN
  logic r_ien;
  logic r_oen;
  assign w_ien = r_ien;
  assign w_oen = r_oen;
`else
  assign w_ien = 1'b1;
  assign w_oen = 1'b1;
`endif

  assign w_d   = DATAIN & {WIDTH{w_ien}};
  assign w_add = {1'b0, RR} + {1'b0, w_d}  + {{WIDTH{1'b0}}, C};
  assign w_sub = {1'b0, RR} + {1'b0, ~w_d} + {{WIDTH{1'b0}}, C};

  always_comb begin
    w_rr_nx   = RR;
    w_c_nx    = C;
    w_ien_nx  = w_ien;
    w_oen_nx  = w_oen;
    w_skip_nx = 1'b0;
    w_fl0_nx  = 1'b0;
    w_jmp_nx  = 1'b0;
    w_rtn_nx  = 1'b0;
    w_flf_nx  = 1'b0;
    w_wrt_nx  = 1'b0;
    w_dout_nx = '0;
    // A pending skip turns this instruction into a silent NOP and cannot re-arm.
    if (!r_skip) begin
      case (IR)
        c_op_nop0: w_fl0_nx = 1'b1;
        c_op_ld:   w_rr_nx  = w_d;
        c_op_add:  {w_c_nx, w_rr_nx} = w_add;
        c_op_sub:  {w_c_nx, w_rr_nx} = w_sub;
        c_op_one: begin
          w_rr_nx = '1;
          w_c_nx  = 1'b0;
        end
        c_op_nand: w_rr_nx = ~(RR & w_d);
        c_op_or:   w_rr_nx = RR | w_d;
        c_op_xor:  w_rr_nx = RR ^ w_d;
        c_op_sto: begin
          w_wrt_nx  = w_oen;
          w_dout_nx = w_oen ? RR : '0;
        end
        c_op_stoc: begin
          w_wrt_nx  = w_oen;
          w_dout_nx = w_oen ? ~RR : '0;
        end
        c_op_ien:  w_ien_nx = DATAIN[0];
        c_op_oen:  w_oen_nx = DATAIN[0];
        c_op_jmp:  w_jmp_nx = 1'b1;
        c_op_rtn: begin
          w_rtn_nx  = 1'b1;
          w_skip_nx = 1'b1;
        end
        c_op_skz:  w_skip_nx = (RR == '0);
        c_op_nopf: w_flf_nx  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RR      <= '0;
      C       <= 1'b0;
      r_skip  <= 1'b0;
      FL0     <= 1'b0;
      JMP     <= 1'b0;
      RTN     <= 1'b0;
      FLF     <= 1'b0;
      WRT     <= 1'b0;
      DATAOUT <= '0;
    end else begin
      RR      <= w_rr_nx;
      C       <= w_c_nx;
      r_skip  <= w_skip_nx;
      FL0     <= w_fl0_nx;
      JMP     <= w_jmp_nx;
      RTN     <= w_rtn_nx;
      FLF     <= w_flf_nx;
      WRT     <= w_wrt_nx;
      DATAOUT <= w_dout_nx;
    end
  end

`ifdef UE_IO_GATE_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ien <= 1'b0;
      r_oen <= 1'b0;
    end else begin
      r_ien <= w_ien_nx;
      r_oen <= w_oen_nx;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_ien_nx ^ w_oen_nx;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ue14500_wide.sv
//==============================================================================
// tb_ue14500_wide : directed self-checking bench for ue14500_wide (WIDTH=4).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_ue14500_wide;

`ifdef UE_IO_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ir = 4'h0;
  logic [3:0] din = 4'h0;
  logic       fl0, jmp, rtn, flf, wrt, c;
  logic [3:0] dout, rr;

  int n_cmp = 0;
  int n_err = 0;

  ue14500_wide #(.WIDTH(4)) dut (
    .CLK(clk), .RST(rst), .IR(ir), .DATAIN(din),
    .FL0(fl0), .JMP(jmp), .RTN(rtn), .FLF(flf),
    .DATAOUT(dout), .WRT(wrt), .RR(rr), .C(c)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [3:0] op, input logic [3:0] data);
    ir  = op;
    din = data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // strobe vector order: {FL0, JMP, RTN, FLF, WRT}
  function automatic logic [15:0] stb();
    return {11'b0, fl0, jmp, rtn, flf, wrt};
  endfunction

  initial begin
    // reset
    rst = 1'b1;
    step(4'hC, 4'h0);
    step(4'hC, 4'h0);
    chk("rst_rr", rr, 0);
    chk("rst_c", c, 0);
    chk("rst_stb", stb(), 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;

    step(4'h1, 4'hA);
    chk("ld_gated", rr, GATE ? 16'h0 : 16'hA);
    step(4'hA, 4'h1);
    chk("ien_stb", stb(), 0);
    step(4'h1, 4'hA);
    chk("ld_a", rr, 16'hA);

    // arithmetic
    step(4'h4, 4'h0);
    chk("one_rr", rr, 16'hF);
    chk("one_c", c, 0);
    step(4'h1, 4'h9);
    step(4'h2, 4'h8);
    chk("add1_rr", rr, 16'h1);
    chk("add1_c", c, 1);
    step(4'h2, 4'h0);
    chk("add2_rr", rr, 16'h2);
    chk("add2_c", c, 0);
    step(4'h3, 4'h3);
    chk("sub_rr", rr, 16'hE);
    chk("sub_c", c, 0);
    step(4'h7, 4'h5);
    chk("xor_rr", rr, 16'hB);
    step(4'h5, 4'h6);
    chk("nand_rr", rr, 16'hD);
    step(4'h6, 4'h2);
    chk("or_rr", rr, 16'hF);

    // stores
    step(4'hB, 4'h1);
    step(4'h1, 4'h5);
    step(4'h8, 4'h0);
    chk("sto_wrt", wrt, 1);
    chk("sto_dout", dout, 16'h5);
    step(4'h9, 4'h0);
    chk("stoc_wrt", wrt, 1);
    chk("stoc_dout", dout, 16'hA);
    step(4'hB, 4'h0);
    chk("oen0_stb", stb(), 0);
    chk("oen0_dout", dout, 0);
    step(4'h8, 4'h0);
    chk("sto_off_wrt", wrt, GATE ? 16'h0 : 16'h1);
    chk("sto_off_dout", dout, GATE ? 16'h0 : 16'h5);

    // skip on zero
    step(4'h1, 4'h0);
    step(4'hE, 4'h0);
    chk("skz_stb", stb(), 0);
    step(4'hC, 4'h0);
    chk("skipped_jmp", stb(), 0);
    step(4'hC, 4'h0);
    chk("jmp_after", stb(), 16'h08);
    step(4'h1, 4'h1);
    step(4'hE, 4'h0);
    step(4'hC, 4'h0);
    chk("skz_nz_jmp", stb(), 16'h08);
    step(4'h1, 4'h0);
    step(4'hE, 4'h0);
    step(4'hE, 4'h0);
    step(4'hC, 4'h0);
    chk("no_chain_jmp", stb(), 16'h08);
    step(4'hE, 4'h0);
    step(4'h1, 4'h7);
    chk("skipped_ld", rr, 16'h0);

    // RTN and flag strobes
    step(4'hD, 4'h0);
    chk("rtn_stb", stb(), 16'h04);
    step(4'hF, 4'h0);
    chk("nopf_skip", stb(), 0);
    step(4'hF, 4'h0);
    chk("nopf_stb", stb(), 16'h02);
    step(4'h0, 4'h0);
    chk("nop0_stb", stb(), 16'h10);
    step(4'h1, 4'h0);
    chk("stb_clear", stb(), 0);

    // reset during pending skip
    step(4'hE, 4'h0);
    rst = 1'b1;
    step(4'hC, 4'h0);
    chk("rst_mid_stb", stb(), 0);
    rst = 1'b0;
    step(4'hC, 4'h0);
    chk("post_rst_jmp", stb(), 16'h08);
    step(4'h1, 4'h7);
    chk("post_rst_ld", rr, GATE ? 16'h0 : 16'h7);
    chk("post_rst_c", c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
